// File: rtl/fib_seq_gen.sv
// rtl/fib_seq_gen.sv - Fibonacci-class sequence generator with valid/ready term stream
//
// Purpose: emits len terms of t[k] = t[k-2] + t[k-1] starting from two programmable
// seeds. Arithmetic is either modulo 2^DATA_WIDTH or saturating. Each term carries a
// sticky overflow flag. One term is emitted per cycle while the consumer is ready.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   start, abort         begin a run (IDLE only) / terminate a run (any state)
//   seed0, seed1         terms 0 and 1, sampled on an accepted start
//   len, sat_en          term count and saturate-mode select, sampled on an accepted start
//   out_ready            consumer ready
//   out_valid, out       term stream: valid flag and term value
//   out_idx, out_ovf     0-based term index and overflow-affected flag
//   busy, done           run in progress / one-cycle pulse after the final handshake
module fib_seq_gen #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] seed0,
   input  logic [DATA_WIDTH-1:0] seed1,
   input  logic [CNT_WIDTH-1:0]  len,
   input  logic                  sat_en,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out,
   output logic [CNT_WIDTH-1:0]  out_idx,
   output logic                  out_ovf,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] a, b;
   logic                  a_ovf, b_ovf;
   logic [CNT_WIDTH-1:0]  idx, len_r;
   logic                  sat_r;
   logic                  done_r, done_nxt;
   logic                  start_ok, hs, last;
   logic [DATA_WIDTH:0]   raw_sum;
   logic                  carry;
   logic [DATA_WIDTH-1:0] sum;

   // One extra bit on the adder exposes the carry used for both saturation and the flag.
   assign raw_sum  = {1'b0, a} + {1'b0, b};
   assign carry    = raw_sum[DATA_WIDTH];
   assign sum      = (sat_r && carry) ? '1 : raw_sum[DATA_WIDTH-1:0];

   assign start_ok = (state == IDLE) && start && !abort;
   assign hs       = (state == RUN) && out_ready && !abort;
   assign last     = (idx == len_r - CNT_WIDTH'(1));

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  // A zero-length run never enters RUN but still reports completion.
                  if (len == '0) done_nxt  = 1'b1;
                  else           state_nxt = RUN;
               end
            end
            RUN: begin
               if (out_ready && last) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         done_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_r <= done_nxt;
      end
   end

   // Term pipeline: a is the term on display, b the next one. Flags shift with the terms
   // and b_ovf accumulates, so once any term overflows all later terms stay flagged.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         a     <= '0;
         b     <= '0;
         a_ovf <= 1'b0;
         b_ovf <= 1'b0;
         idx   <= '0;
         len_r <= '0;
         sat_r <= 1'b0;
      end else if (start_ok) begin
         a     <= seed0;
         b     <= seed1;
         a_ovf <= 1'b0;
         b_ovf <= 1'b0;
         idx   <= '0;
         len_r <= len;
         sat_r <= sat_en;
      end else if (hs) begin
         a     <= b;
         b     <= sum;
         a_ovf <= b_ovf;
         b_ovf <= carry | a_ovf | b_ovf;
         idx   <= idx + CNT_WIDTH'(1);
      end
   end

   assign out_valid = (state == RUN);
   assign busy      = (state == RUN);
   assign out       = a;
   assign out_idx   = idx;
   assign out_ovf   = a_ovf;
   assign done      = done_r;

endmodule

// File: tb/tb_fib_seq_gen.sv
// tb/tb_fib_seq_gen.sv - self-checking bench for fib_seq_gen
module tb_fib_seq_gen;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] seed0 = '0;
   logic [31:0] seed1 = '0;
   logic [15:0] len = '0;
   logic        sat_en = 1'b0;
   logic        out_ready = 1'b0;
   logic        out_valid, out_ovf, busy, done;
   logic [31:0] out;
   logic [15:0] out_idx;

   logic        s8_start = 1'b0;
   logic [7:0]  s8_seed0 = '0;
   logic [7:0]  s8_seed1 = '0;
   logic        s8_valid, s8_ovf, s8_busy, s8_done;
   logic [7:0]  s8_out;
   logic [15:0] s8_idx;

   int checks = 0;
   int passes = 0;

   longint exp_val [0:63];
   bit     exp_ovf [0:63];

   always #5 clk = ~clk;

   fib_seq_gen dut (
      .clk(clk), .resetn(resetn), .start(start), .abort(abort),
      .seed0(seed0), .seed1(seed1), .len(len), .sat_en(sat_en),
      .out_ready(out_ready), .out_valid(out_valid), .out(out),
      .out_idx(out_idx), .out_ovf(out_ovf), .busy(busy), .done(done)
   );

   fib_seq_gen #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut8 (
      .clk(clk), .resetn(resetn), .start(s8_start), .abort(abort),
      .seed0(s8_seed0), .seed1(s8_seed1), .len(len), .sat_en(sat_en),
      .out_ready(out_ready), .out_valid(s8_valid), .out(s8_out),
      .out_idx(s8_idx), .out_ovf(s8_ovf), .busy(s8_busy), .done(s8_done)
   );

   // Reference sequence from the recurrence using wide integer arithmetic.
   task automatic build_model(input int w, input longint s0, input longint s1,
                              input int n, input bit sat);
      longint mx, s;
      bit     c;
      mx = (longint'(1) << w) - 1;
      for (int k = 0; k < n; k++) begin
         if (k == 0) begin
            exp_val[k] = s0 & mx; exp_ovf[k] = 1'b0;
         end else if (k == 1) begin
            exp_val[k] = s1 & mx; exp_ovf[k] = 1'b0;
         end else begin
            s = exp_val[k-2] + exp_val[k-1];
            c = (s > mx);
            exp_val[k] = !c ? s : (sat ? mx : s - (mx + 1));
            exp_ovf[k] = c || exp_ovf[k-1] || exp_ovf[k-2];
         end
      end
   endtask

   task automatic do_start(input logic [31:0] s0, input logic [31:0] s1, input int n, input bit sat);
      seed0 = s0; seed1 = s1; len = 16'(n); sat_en = sat; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; seed0 = $urandom; seed1 = $urandom; len = 16'($urandom); sat_en = ~sat;
   endtask

   // mode 0: ready always, 1: ready pattern 1,0,0, 2: random ready plus stray start pulses
   task automatic stream(input int n, input int mode, input bit chain);
      int k, cyc;
      k = 0; cyc = 0;
      while (k < n && cyc < 4000) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (mode == 2) begin
            start = 1'($urandom_range(0, 1)); seed0 = $urandom; seed1 = $urandom;
            len = 16'($urandom); sat_en = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
            $display("FAIL stream_ctl idx %0d: valid/busy/done got %b%b%b want 110", k, out_valid, busy, done);
         else passes++;
         checks++;
         if (out !== 32'(exp_val[k]) || out_idx !== 16'(k) || out_ovf !== exp_ovf[k])
            $display("FAIL stream_term: got out=%0d idx=%0d ovf=%b want out=%0d idx=%0d ovf=%b",
                     out, out_idx, out_ovf, 32'(exp_val[k]), k, exp_ovf[k]);
         else passes++;
         if (out_ready) k++;
         cyc++;
         @(posedge clk); #1;
      end
      start = 1'b0; out_ready = 1'b0;
      checks++;
      if (k != n) $display("FAIL stream_timeout: got %0d handshakes want %0d", k, n);
      else passes++;
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL done_pulse: done/valid/busy got %b%b%b want 100", done, out_valid, busy);
      else passes++;
      if (!chain) begin
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL done_single: done/valid got %b%b want 00", done, out_valid);
         else passes++;
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (out_valid !== 1'b0 || out !== 32'd0 || out_idx !== 16'd0 || out_ovf !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0)
         $display("FAIL reset_outputs: got valid=%b out=%0d idx=%0d ovf=%b busy=%b done=%b want all 0",
                  out_valid, out, out_idx, out_ovf, busy, done);
      else passes++;
      @(negedge clk); resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      build_model(32, 1, 1, 8, 1'b0);
      do_start(1, 1, 8, 1'b0);
      stream(8, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      build_model(32, 2, 1, 5, 1'b0);
      do_start(2, 1, 5, 1'b0);
      stream(5, 1, 1'b0);
   endtask

   task automatic test_overflow8(input bit sat);
      build_model(8, 1, 1, 15, sat);
      s8_seed0 = 8'd1; s8_seed1 = 8'd1; len = 16'd15; sat_en = sat; s8_start = 1'b1;
      @(posedge clk); #1;
      s8_start = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         checks++;
         if (s8_valid !== 1'b1 || s8_out !== 8'(exp_val[k]) || s8_idx !== 16'(k) || s8_ovf !== exp_ovf[k])
            $display("FAIL ovf8_term: got valid=%b out=%0d idx=%0d ovf=%b want 1 out=%0d idx=%0d ovf=%b",
                     s8_valid, s8_out, s8_idx, s8_ovf, 8'(exp_val[k]), k, exp_ovf[k]);
         else passes++;
         if (k >= 12) begin
            checks++;
            if (k == 12 && (s8_out !== 8'd233 || s8_ovf !== 1'b0))
               $display("FAIL ovf8_idx12: got %0d/%b want 233/0", s8_out, s8_ovf);
            else if (k == 13 && (s8_out !== (sat ? 8'd255 : 8'd121) || s8_ovf !== 1'b1))
               $display("FAIL ovf8_idx13: got %0d/%b want %0d/1", s8_out, s8_ovf, sat ? 255 : 121);
            else if (k == 14 && (s8_out !== (sat ? 8'd255 : 8'd98) || s8_ovf !== 1'b1))
               $display("FAIL ovf8_idx14: got %0d/%b want %0d/1", s8_out, s8_ovf, sat ? 255 : 98);
            else passes++;
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (s8_done !== 1'b1 || s8_valid !== 1'b0)
         $display("FAIL ovf8_done: done/valid got %b%b want 10", s8_done, s8_valid);
      else passes++;
   endtask

   task automatic test_len0();
      do_start(32'd5, 32'd6, 0, 1'b0);
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL len0_done: done/valid/busy got %b%b%b want 100", done, out_valid, busy);
      else passes++;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL len0_after: done/valid got %b%b want 00", done, out_valid);
      else passes++;
   endtask

   task automatic test_len1();
      build_model(32, 32'd7, 32'd9, 1, 1'b0);
      do_start(32'd7, 32'd9, 1, 1'b0);
      stream(1, 0, 1'b0);
   endtask

   task automatic test_start_in_run();
      build_model(32, 32'd10, 32'd20, 12, 1'b0);
      do_start(32'd10, 32'd20, 12, 1'b0);
      stream(12, 2, 1'b0);
   endtask

   task automatic test_back_to_back();
      build_model(32, 32'd3, 32'd4, 3, 1'b0);
      do_start(32'd3, 32'd4, 3, 1'b0);
      stream(3, 0, 1'b1);
      build_model(32, 32'hFFFF_FFF0, 32'h20, 4, 1'b1);
      do_start(32'hFFFF_FFF0, 32'h20, 4, 1'b1);
      stream(4, 0, 1'b0);
   endtask

   task automatic test_abort();
      build_model(32, 1, 1, 8, 1'b0);
      do_start(1, 1, 8, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (out_idx !== 16'(i) || out !== 32'(exp_val[i]))
            $display("FAIL abort_pre: got idx=%0d out=%0d want idx=%0d out=%0d", out_idx, out, i, 32'(exp_val[i]));
         else passes++;
         if (i == 3) abort = 1'b1;
         @(posedge clk); #1;
      end
      abort = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
         $display("FAIL abort_run: valid/busy/done got %b%b%b want 000", out_valid, busy, done);
      else passes++;
      // abort on the cycle of the final handshake
      do_start(1, 1, 2, 1'b0);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL abort_final: done/valid got %b%b want 00", done, out_valid);
      else passes++;
      // abort together with start in IDLE
      start = 1'b1; abort = 1'b1; len = 16'd4;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
         $display("FAIL abort_start: valid/busy/done got %b%b%b want 000", out_valid, busy, done);
      else passes++;
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] s0, s1;
      int          n;
      bit          sat;
      for (int r = 0; r < 6; r++) begin
         s0 = $urandom; s1 = $urandom;
         if (r < 2) begin s0 = s0 >> 8; s1 = s1 >> 8; end
         n = $urandom_range(1, 40);
         sat = 1'($urandom_range(0, 1));
         build_model(32, longint'(s0), longint'(s1), n, sat);
         do_start(s0, s1, n, sat);
         stream(n, 2, 1'b0);
      end
   endtask

   task automatic test_async_reset();
      do_start(1, 1, 8, 1'b0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2;
      checks++;
      if (out_valid !== 1'b1 || out !== 32'd2)
         $display("FAIL areset_pre: valid/out got %b/%0d want 1/2", out_valid, out);
      else passes++;
      resetn = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out !== 32'd0 || busy !== 1'b0 || out_idx !== 16'd0)
         $display("FAIL areset_now: valid=%b out=%0d busy=%b idx=%0d want all 0", out_valid, out, busy, out_idx);
      else passes++;
      out_ready = 1'b0;
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || done !== 1'b0)
         $display("FAIL areset_after: valid/done got %b%b want 00", out_valid, done);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_overflow8(1'b0);
      test_overflow8(1'b1);
      test_len0();
      test_len1();
      test_start_in_run();
      test_back_to_back();
      test_abort();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
